ble_rx_sequencer: RTL and testbench
===================================

Name: ble_rx_sequencer

Overview:
- Packet-level controller for the BLE receive datapath. Sits after the demodulator and clock recovery.
- Gates preamble_detected into clock recovery and consumes the recovered symbol_clk strobe and demodulated bit.
- Frames the packet in order: access-address (AA) search, header, then payload+CRC.
- Emits framed bits, length, and start/done/abort strobes to the link layer.

Parameters:
ACCESS_ADDR, 32'h8E89BED6, expected AA, transmitted LSB first
AA_MAX_ERR, 1, maximum bit mismatches accepted in the AA match
SYNC_TIMEOUT_SYM, 40, symbols allowed in AA_SEARCH before abort
MAX_PDU_BYTES, 37, largest legal header length field
CRC_BYTES, 3, bytes following the PDU payload

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
en  in  1  sample-rate enable; all state updates only when en=1
rx_enable  in  1  link-layer receive enable (level)
preamble_detected  in  1  raw preamble detector output
symbol_clk  in  1  symbol strobe from clock recovery
demod_bit  in  1  demodulated bit, valid when symbol_clk=1
cr_preamble_detected  out  1  gated preamble pulse to clock recovery
bit_out  out  1  framed header/payload/CRC bit
bit_valid  out  1  bit_out qualifier
aa_match  out  1  AA accepted pulse
packet_done  out  1  last CRC bit delivered pulse
packet_abort  out  1  timeout, bad length or disable pulse
pdu_length  out  8  latched header length byte
packet_active  out  1  high in HEADER and PAYLOAD
state_o  out  3  current state encoding

Behaviour:
- Reset and enable
  - Reset is synchronous and active-high and overrides en.
  - On reset: state=IDLE; all outputs 0; pdu_length=0; counters and shift register cleared.
- Register timing
  - Every register, outputs included, updates only on clk edges where en=1.
  - A "pulse" is therefore high for exactly one en-period: set on one en edge, cleared on the next.
  - All outputs are registered, so outputs reflect the decision made on the previous en edge.
- Symbol event: symbol_clk=1 and en=1. demod_bit is sampled only on symbol events.
- States (encoding IDLE=0, SEARCH=1, AA_SEARCH=2, HEADER=3, PAYLOAD=4):
  - IDLE: rx_enable=1 -> SEARCH.
  - SEARCH: preamble_detected=1 -> cr_preamble_detected pulse; clear the AA shift register and symbol counter; go to AA_SEARCH.
  - AA_SEARCH
    - On each symbol event, shift demod_bit into the MSB of a 32-bit register (shift right) and increment sym_cnt, saturating.
    - Once sym_cnt>=32, compute popcount(reg XOR ACCESS_ADDR). If it is <=AA_MAX_ERR: aa_match pulse, clear bit_cnt, go to HEADER.
    - Else if sym_cnt==SYNC_TIMEOUT_SYM: packet_abort pulse, go to SEARCH.
    - A match on the timeout symbol itself wins over the timeout.
  - HEADER
    - On each symbol event, drive bit_out=demod_bit and bit_valid=1 for one en-period.
    - Bits 8..15 are assembled LSB first into the length byte.
    - On bit 15, latch pdu_length.
    - If length>MAX_PDU_BYTES: packet_abort, go to SEARCH. Bit 15 is still delivered with bit_valid.
    - Otherwise load rem_bits=(length+CRC_BYTES)*8 and go to PAYLOAD.
    - rem_bits is 9 bits wide, enough for a maximum of 320.
  - PAYLOAD
    - Forward bits as in HEADER and decrement rem_bits on each symbol event.
    - The bit on which rem_bits==1 asserts packet_done together with bit_valid.
    - Next state is SEARCH if rx_enable=1, else IDLE.
    - length=0 still yields 24 CRC bits.
- Global rules
  - rx_enable=0 in any non-IDLE state forces IDLE on the next en edge.
  - Disabling from AA_SEARCH, HEADER or PAYLOAD also pulses packet_abort.
  - rx_enable=0 has priority over every other event in the same cycle, including packet_done.
  - preamble_detected is ignored outside SEARCH; cr_preamble_detected is never asserted outside SEARCH.
  - A symbol event with en=0 is not possible: symbol_clk is sampled only with en.
  - packet_active is high exactly while in HEADER or PAYLOAD.
  - pdu_length holds its value until the next HEADER completes.

Decomposition:
- Package ble_rx_pkg holds:
  - the state enum (3-bit);
  - BLE_ADV_ACCESS_ADDR;
  - CRC_BYTES;
  - HEADER_BITS=16;
  - LEN_BIT_LSB=8;
  - the rem_bits width localparam.
- Sub-module aa_correlator:
  - 32-bit shift register, popcount and compare;
  - inputs clk, reset, en, clear, shift, bit;
  - output match.
- The sequencer holds the FSM, counters and output registers.

Test Plan:
1. rx_enable=1, preamble at t0, then AA 0x8E89BED6 LSB first followed by header 0x00,0x05 and 64 bits → cr_preamble_detected one pulse; aa_match after 32nd symbol; pdu_length=5; 16+64 bit_valid pulses; packet_done on the 80th framed bit; state returns to SEARCH.
2. AA with one bit flipped (bit 7) → aa_match asserted. AA with two flipped bits → no match; packet_abort on symbol 40; state SEARCH.
3. Header length byte 0x30 (48>37) → packet_abort on header bit 15; state SEARCH; no PAYLOAD entry; pdu_length=0x30.
4. Length 0 → exactly 24 PAYLOAD bits; packet_done on the 40th framed bit.
5. rx_enable dropped mid-PAYLOAD (bit 20) → packet_abort pulse; state IDLE next en edge; no packet_done. Dropped in the same cycle as the last bit → IDLE plus abort, and packet_done stays 0.
6. Reset asserted mid-HEADER with en=0 → next clk edge gives state IDLE and all outputs 0. preamble_detected toggling during AA_SEARCH → no extra cr_preamble_detected.

Source files
------------

// File: rtl/ble_rx_sequencer_pkg.sv
// Shared types and constants for the BLE receive packet sequencer.
package ble_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEARCH    = 3'd1,
      ST_AA_SEARCH = 3'd2,
      ST_HEADER    = 3'd3,
      ST_PAYLOAD   = 3'd4
   } rx_state_e;

   localparam logic [31:0] BLE_ADV_ACCESS_ADDR = 32'h8E89_BED6;
   localparam int          CRC_BYTES           = 3;
   localparam int          HEADER_BITS         = 16;
   localparam int          LEN_BIT_LSB         = 8;
   // (37 + 3) * 8 = 320 framed payload bits is the largest count to hold
   localparam int          REM_BITS_W          = 9;
   localparam int          SYM_CNT_W           = 8;

   function automatic int popcount32(input logic [31:0] v);
      int cnt;
      cnt = 0;
      for (int i = 0; i < 32; i++) begin
         cnt += int'(v[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/ble_rx_sequencer_if.sv
// Receive-side signal bundle between the demod/clock-recovery front end and the sequencer.
interface ble_rx_sequencer_if;

   logic       rx_enable;
   logic       preamble_detected;
   logic       symbol_clk;
   logic       demod_bit;
   logic       cr_preamble_detected;
   logic       bit_out;
   logic       bit_valid;
   logic       aa_match;
   logic       packet_done;
   logic       packet_abort;
   logic [7:0] pdu_length;
   logic       packet_active;
   logic [2:0] state_o;

   modport master (
      output rx_enable,
      output preamble_detected,
      output symbol_clk,
      output demod_bit,
      input  cr_preamble_detected,
      input  bit_out,
      input  bit_valid,
      input  aa_match,
      input  packet_done,
      input  packet_abort,
      input  pdu_length,
      input  packet_active,
      input  state_o
   );

   modport slave (
      input  rx_enable,
      input  preamble_detected,
      input  symbol_clk,
      input  demod_bit,
      output cr_preamble_detected,
      output bit_out,
      output bit_valid,
      output aa_match,
      output packet_done,
      output packet_abort,
      output pdu_length,
      output packet_active,
      output state_o
   );

endinterface

// File: rtl/ble_rx_sequencer_aa_correlator.sv
// Access-address correlator: LSB-first shift register with a Hamming-distance threshold.
module aa_correlator
   import ble_rx_pkg::*;
#(
   parameter logic [31:0] ACCESS_ADDR = BLE_ADV_ACCESS_ADDR,
   parameter int          AA_MAX_ERR  = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clear,
   input  logic shift,
   input  logic shift_bit,
   output logic match
);

   logic [31:0] aa_sr;
   logic [31:0] aa_sr_next;

   always_comb begin
      aa_sr_next = {shift_bit, aa_sr[31:1]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         aa_sr <= '0;
      end else if (en) begin
         if (clear) begin
            aa_sr <= '0;
         end else if (shift) begin
            aa_sr <= aa_sr_next;
         end
      end
   end

   // Scored on the post-shift value so the sequencer can accept on the same symbol event.
   assign match = (popcount32(aa_sr_next ^ ACCESS_ADDR) <= AA_MAX_ERR);

endmodule

// File: rtl/ble_rx_sequencer.sv
// BLE receive packet sequencer: preamble gating, access-address search and header/payload framing.
module ble_rx_sequencer
   import ble_rx_pkg::*;
#(
   parameter logic [31:0] ACCESS_ADDR      = BLE_ADV_ACCESS_ADDR,
   parameter int          AA_MAX_ERR       = 1,
   parameter int          SYNC_TIMEOUT_SYM = 40,
   parameter int          MAX_PDU_BYTES    = 37,
   parameter int          CRC_BYTES        = ble_rx_pkg::CRC_BYTES
) (
   input logic               clk,
   input logic               reset,
   input logic               en,
   ble_rx_sequencer_if.slave rx
);

   rx_state_e              state;
   logic [SYM_CNT_W-1:0]   sym_cnt;
   logic [SYM_CNT_W-1:0]   sym_cnt_inc;
   logic [3:0]             bit_cnt;
   logic [7:0]             len_sr;
   logic [7:0]             len_next;
   logic [REM_BITS_W-1:0]  rem_bits;
   logic [REM_BITS_W-1:0]  rem_load;

   logic                   corr_clear;
   logic                   corr_shift;
   logic                   corr_match;
   logic                   aa_ready;
   logic                   timeout_hit;
   logic                   len_too_long;
   logic                   in_frame;

   logic                   cr_pulse_q;
   logic                   bit_out_q;
   logic                   bit_valid_q;
   logic                   aa_match_q;
   logic                   done_q;
   logic                   abort_q;
   logic [7:0]             pdu_len_q;
   logic                   active_q;

   // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
   always_comb begin
      corr_clear   = (state == ST_SEARCH) && rx.rx_enable && rx.preamble_detected;
      corr_shift   = (state == ST_AA_SEARCH) && rx.rx_enable && rx.symbol_clk;
      sym_cnt_inc  = (sym_cnt == '1) ? sym_cnt : sym_cnt + SYM_CNT_W'(1);
      aa_ready     = (sym_cnt_inc >= SYM_CNT_W'(32));
      timeout_hit  = (sym_cnt_inc == SYM_CNT_W'(SYNC_TIMEOUT_SYM));
      len_next     = {rx.demod_bit, len_sr[7:1]};
      len_too_long = (int'(len_next) > MAX_PDU_BYTES);
      rem_load     = REM_BITS_W'((int'(len_next) + CRC_BYTES) * 8);
      in_frame     = (state == ST_AA_SEARCH) || (state == ST_HEADER) || (state == ST_PAYLOAD);
   end

   aa_correlator #(
      .ACCESS_ADDR (ACCESS_ADDR),
      .AA_MAX_ERR  (AA_MAX_ERR)
   ) u_aa_correlator (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .clear     (corr_clear),
      .shift     (corr_shift),
      .shift_bit (rx.demod_bit),
      .match     (corr_match)
   );

   // NOTE: sequential state uses non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         sym_cnt     <= '0;
         bit_cnt     <= '0;
         len_sr      <= '0;
         rem_bits    <= '0;
         cr_pulse_q  <= 1'b0;
         bit_out_q   <= 1'b0;
         bit_valid_q <= 1'b0;
         aa_match_q  <= 1'b0;
         done_q      <= 1'b0;
         abort_q     <= 1'b0;
         pdu_len_q   <= '0;
         active_q    <= 1'b0;
      end else if (en) begin
         cr_pulse_q  <= 1'b0;
         bit_valid_q <= 1'b0;
         aa_match_q  <= 1'b0;
         done_q      <= 1'b0;
         abort_q     <= 1'b0;

         // Losing rx_enable outranks every in-flight event, including the final CRC bit.
         if ((state != ST_IDLE) && !rx.rx_enable) begin
            state    <= ST_IDLE;
            active_q <= 1'b0;
            abort_q  <= in_frame;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (rx.rx_enable) state <= ST_SEARCH;
               end

               ST_SEARCH: begin
                  if (rx.preamble_detected) begin
                     cr_pulse_q <= 1'b1;
                     sym_cnt    <= '0;
                     state      <= ST_AA_SEARCH;
                  end
               end

               ST_AA_SEARCH: begin
                  if (rx.symbol_clk) begin
                     sym_cnt <= sym_cnt_inc;
                     if (aa_ready && corr_match) begin
                        aa_match_q <= 1'b1;
                        bit_cnt    <= '0;
                        len_sr     <= '0;
                        active_q   <= 1'b1;
                        state      <= ST_HEADER;
                     end else if (timeout_hit) begin
                        abort_q <= 1'b1;
                        state   <= ST_SEARCH;
                     end
                  end
               end

               ST_HEADER: begin
                  if (rx.symbol_clk) begin
                     bit_out_q   <= rx.demod_bit;
                     bit_valid_q <= 1'b1;
                     bit_cnt     <= bit_cnt + 4'd1;
                     if (bit_cnt >= 4'(LEN_BIT_LSB)) len_sr <= len_next;
                     if (bit_cnt == 4'(HEADER_BITS - 1)) begin
                        pdu_len_q <= len_next;
                        if (len_too_long) begin
                           abort_q  <= 1'b1;
                           active_q <= 1'b0;
                           state    <= ST_SEARCH;
                        end else begin
                           rem_bits <= rem_load;
                           state    <= ST_PAYLOAD;
                        end
                     end
                  end
               end

               ST_PAYLOAD: begin
                  if (rx.symbol_clk) begin
                     bit_out_q   <= rx.demod_bit;
                     bit_valid_q <= 1'b1;
                     rem_bits    <= rem_bits - REM_BITS_W'(1);
                     if (rem_bits == REM_BITS_W'(1)) begin
                        done_q   <= 1'b1;
                        active_q <= 1'b0;
                        state    <= rx.rx_enable ? ST_SEARCH : ST_IDLE;
                     end
                  end
               end

               default: begin
                  active_q <= 1'b0;
                  state    <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign rx.cr_preamble_detected = cr_pulse_q;
   assign rx.bit_out              = bit_out_q;
   assign rx.bit_valid            = bit_valid_q;
   assign rx.aa_match             = aa_match_q;
   assign rx.packet_done          = done_q;
   assign rx.packet_abort         = abort_q;
   assign rx.pdu_length           = pdu_len_q;
   assign rx.packet_active        = active_q;
   assign rx.state_o              = state;

endmodule

// File: tb/tb_ble_rx_sequencer.sv
// Directed bench for ble_rx_sequencer: framing, AA tolerance, timeout, length abort, disable and reset.
module tb_ble_rx_sequencer;

   localparam logic [31:0] AA = 32'h8E89_BED6;
   localparam logic [2:0]  S_IDLE = 3'd0, S_SEARCH = 3'd1, S_AA = 3'd2, S_HDR = 3'd3, S_PAY = 3'd4;

   logic clk = 1'b0;
   logic reset;
   logic en;

   ble_rx_sequencer_if ifc ();

   ble_rx_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .rx    (ifc)
   );

   always #5 clk = ~clk;

   // Pulse bookkeeping on the falling edge, where registered outputs are stable.
   int   n_valid = 0, n_cr = 0, n_match = 0, n_done = 0, n_abort = 0, n_pay_cyc = 0;
   int   done_idx = 0;
   logic framed_q[$];

   always @(negedge clk) begin
      if (ifc.bit_valid) framed_q.push_back(ifc.bit_out);
      if (ifc.packet_done) begin
         n_done++;
         done_idx = framed_q.size();
      end
      if (ifc.bit_valid)            n_valid++;
      if (ifc.cr_preamble_detected) n_cr++;
      if (ifc.aa_match)             n_match++;
      if (ifc.packet_abort)         n_abort++;
      if (ifc.state_o == S_PAY)     n_pay_cyc++;
   end

   int   n_checks = 0;
   int   n_errors = 0;
   int   b_valid, b_cr, b_match, b_done, b_abort, b_pay, b_q;
   logic exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic snap();
      b_valid = n_valid; b_cr = n_cr; b_match = n_match; b_done = n_done;
      b_abort = n_abort; b_pay = n_pay_cyc; b_q = framed_q.size();
      exp_q.delete();
   endtask

   task automatic sym(input logic b);
      ifc.symbol_clk = 1'b1;
      ifc.demod_bit  = b;
      tick();
      ifc.symbol_clk = 1'b0;
      ifc.demod_bit  = 1'b0;
      tick();
   endtask

   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = 0; i < n; i++) sym(v[i]);
   endtask

   task automatic frame_bits(input logic [31:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(v[i]);
         sym(v[i]);
      end
   endtask

   task automatic start_packet();
      ifc.preamble_detected = 1'b1;
      tick();
      ifc.preamble_detected = 1'b0;
   endtask

   function automatic int framed_mismatches();
      int m;
      m = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (framed_q[b_q + i] !== exp_q[i]) m++;
      end
      return m;
   endfunction

   initial begin
      reset = 1'b1;
      en    = 1'b1;
      ifc.rx_enable = 1'b0;
      ifc.preamble_detected = 1'b0;
      ifc.symbol_clk = 1'b0;
      ifc.demod_bit = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      check("reset_state", 32'(ifc.state_o), 32'(S_IDLE));
      check("reset_outs", {25'd0, ifc.cr_preamble_detected, ifc.bit_out, ifc.bit_valid, ifc.aa_match,
                           ifc.packet_done, ifc.packet_abort, ifc.packet_active}, 32'd0);
      check("reset_len", 32'(ifc.pdu_length), 32'd0);

      // 1: nominal packet, length 5
      ifc.rx_enable = 1'b1;
      tick();
      check("t1_search", 32'(ifc.state_o), 32'(S_SEARCH));
      snap();
      ifc.preamble_detected = 1'b1;
      tick();
      check("t1_cr_pulse", 32'(ifc.cr_preamble_detected), 32'd1);
      check("t1_aa_state", 32'(ifc.state_o), 32'(S_AA));
      ifc.preamble_detected = 1'b0;
      tick();
      check("t1_cr_once", 32'(n_cr - b_cr), 32'd1);
      send_bits(AA, 31);
      check("t1_no_early_match", 32'(n_match - b_match), 32'd0);
      sym(AA[31]);
      check("t1_match", 32'(n_match - b_match), 32'd1);
      check("t1_hdr_state", 32'(ifc.state_o), 32'(S_HDR));
      check("t1_active", 32'(ifc.packet_active), 32'd1);
      frame_bits(32'h0000_0500, 16);
      check("t1_len", 32'(ifc.pdu_length), 32'd5);
      check("t1_pay_state", 32'(ifc.state_o), 32'(S_PAY));
      frame_bits(32'hA5C3_0F96, 32);
      frame_bits(32'h1234_FEDC, 31);
      check("t1_no_early_done", 32'(n_done - b_done), 32'd0);
      frame_bits(32'h0000_0001, 1);
      check("t1_valid_cnt", 32'(n_valid - b_valid), 32'd80);
      check("t1_done_idx", 32'(done_idx - b_q), 32'd80);
      check("t1_bits", 32'(framed_mismatches()), 32'd0);
      check("t1_end_state", 32'(ifc.state_o), 32'(S_SEARCH));
      check("t1_inactive", 32'(ifc.packet_active), 32'd0);
      check("t1_no_abort", 32'(n_abort - b_abort), 32'd0);

      // 2a: one flipped AA bit still matches; then disable from HEADER
      snap();
      start_packet();
      send_bits(AA ^ 32'h0000_0080, 32);
      check("t2_1err_match", 32'(n_match - b_match), 32'd1);
      check("t2_1err_state", 32'(ifc.state_o), 32'(S_HDR));
      ifc.rx_enable = 1'b0;
      tick();
      check("t2_dis_abort", 32'(ifc.packet_abort), 32'd1);
      check("t2_dis_idle", 32'(ifc.state_o), 32'(S_IDLE));
      ifc.rx_enable = 1'b1;
      tick();

      // 2b: two flipped AA bits never match; timeout on symbol 40
      snap();
      start_packet();
      send_bits(AA ^ 32'h0010_0008, 32);
      check("t2_2err_nomatch", 32'(n_match - b_match), 32'd0);
      send_bits(32'd0, 7);
      check("t2_pre_timeout", 32'(n_abort - b_abort), 32'd0);
      check("t2_pre_timeout_st", 32'(ifc.state_o), 32'(S_AA));
      sym(1'b0);
      check("t2_timeout_abort", 32'(n_abort - b_abort), 32'd1);
      check("t2_timeout_state", 32'(ifc.state_o), 32'(S_SEARCH));
      check("t2_timeout_nomatch", 32'(n_match - b_match), 32'd0);

      // 3: oversize length 0x30 aborts on header bit 15
      snap();
      start_packet();
      send_bits(AA, 32);
      frame_bits(32'h0000_3012, 15);
      check("t3_pre_abort", 32'(n_abort - b_abort), 32'd0);
      frame_bits(32'h0000_0000, 1);
      check("t3_abort", 32'(n_abort - b_abort), 32'd1);
      check("t3_state", 32'(ifc.state_o), 32'(S_SEARCH));
      check("t3_len", 32'(ifc.pdu_length), 32'h30);
      check("t3_valid_cnt", 32'(n_valid - b_valid), 32'd16);
      check("t3_no_payload", 32'(n_pay_cyc - b_pay), 32'd0);

      // 4: length 0 still carries 24 CRC bits
      snap();
      start_packet();
      send_bits(AA, 32);
      frame_bits(32'h0000_0000, 16);
      frame_bits(32'h00C3_5A69, 23);
      check("t4_no_early_done", 32'(n_done - b_done), 32'd0);
      frame_bits(32'h0000_0001, 1);
      check("t4_done", 32'(n_done - b_done), 32'd1);
      check("t4_done_idx", 32'(done_idx - b_q), 32'd40);
      check("t4_valid_cnt", 32'(n_valid - b_valid), 32'd40);
      check("t4_state", 32'(ifc.state_o), 32'(S_SEARCH));

      // 5a: disable on payload bit 20
      snap();
      start_packet();
      send_bits(AA, 32);
      frame_bits(32'h0000_0500, 16);
      frame_bits(32'h000F_0F0F, 20);
      ifc.rx_enable = 1'b0;
      tick();
      check("t5_abort", 32'(ifc.packet_abort), 32'd1);
      check("t5_idle", 32'(ifc.state_o), 32'(S_IDLE));
      check("t5_inactive", 32'(ifc.packet_active), 32'd0);
      check("t5_no_done", 32'(n_done - b_done), 32'd0);

      // 5b: disable coincides with the final CRC bit (length 1 -> 32 payload bits)
      ifc.rx_enable = 1'b1;
      tick();
      snap();
      start_packet();
      send_bits(AA, 32);
      frame_bits(32'h0000_0100, 16);
      frame_bits(32'h5555_AAAA, 31);
      ifc.rx_enable  = 1'b0;
      ifc.symbol_clk = 1'b1;
      ifc.demod_bit  = 1'b1;
      tick();
      check("t5b_abort", 32'(ifc.packet_abort), 32'd1);
      check("t5b_idle", 32'(ifc.state_o), 32'(S_IDLE));
      check("t5b_no_valid", 32'(ifc.bit_valid), 32'd0);
      ifc.symbol_clk = 1'b0;
      ifc.demod_bit  = 1'b0;
      tick();
      check("t5b_no_done", 32'(n_done - b_done), 32'd0);

      // 6: preamble noise in AA_SEARCH, en freeze, reset with en low
      ifc.rx_enable = 1'b1;
      tick();
      snap();
      start_packet();
      for (int i = 0; i < 32; i++) begin
         ifc.preamble_detected = (i % 3) != 0;
         sym(AA[i]);
      end
      ifc.preamble_detected = 1'b0;
      check("t6_single_cr", 32'(n_cr - b_cr), 32'd1);
      check("t6_hdr_state", 32'(ifc.state_o), 32'(S_HDR));
      frame_bits(32'h0000_001F, 5);
      check("t6_len_held", 32'(ifc.pdu_length), 32'd1);
      en = 1'b0;
      ifc.rx_enable = 1'b0;
      tick();
      check("t6_en_freeze", 32'(ifc.state_o), 32'(S_HDR));
      reset = 1'b1;
      tick();
      check("t6_reset_state", 32'(ifc.state_o), 32'(S_IDLE));
      check("t6_reset_outs", {25'd0, ifc.cr_preamble_detected, ifc.bit_out, ifc.bit_valid, ifc.aa_match,
                              ifc.packet_done, ifc.packet_abort, ifc.packet_active}, 32'd0);
      check("t6_reset_len", 32'(ifc.pdu_length), 32'd0);
      reset = 1'b0;
      en    = 1'b1;
      tick();
      check("t6_stay_idle", 32'(ifc.state_o), 32'(S_IDLE));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
